xsleena_video_timing_gen: RTL and testbench
===========================================

// Module: xsleena_video_timing_gen
// PURPOSE
//  Consumer end of the pixel clock-enable stream (HCLKn_cen, 6 MHz at 48 MHz i_clk).
//  Advances raster H/V counters once per enable pulse and decodes blanking, sync,
//  data-enable and line/frame strobes for the video pipeline.
//  Also watches the enable stream and flags loss of pulses (cen_lost).
// PARAMETERS
//  H_TOTAL   384  pixels per line (hcnt wraps H_TOTAL-1 -> 0)
//  H_ACTIVE  256  visible pixels; hblank when hcnt >= H_ACTIVE
//  HS_START  296  first hcnt with hsync=1
//  HS_END    328  first hcnt with hsync=0 again
//  V_TOTAL   272  lines per frame
//  V_ACTIVE  240  visible lines; vblank when vcnt >= V_ACTIVE
//  VS_START  248  first vcnt with vsync=1
//  VS_END    251  first vcnt with vsync=0 again
//  WDOG      16   i_clk cycles without i_pix_cen before o_cen_lost asserts
// PORTS
//  i_clk          in   1  48 MHz system clock
//  i_rst          in   1  synchronous reset, active high
//  i_pix_cen      in   1  pixel clock enable, one-cycle pulse
//  o_hcnt         out  9  horizontal position
//  o_vcnt         out  9  vertical position
//  o_hblank       out  1  horizontal blanking
//  o_vblank       out  1  vertical blanking
//  o_hsync        out  1  horizontal sync, active high
//  o_vsync        out  1  vertical sync, active high
//  o_de           out  1  data enable = ~hblank & ~vblank
//  o_line_start   out  1  one i_clk pulse when hcnt becomes 0
//  o_frame_start  out  1  one i_clk pulse when (hcnt,vcnt) becomes (0,0)
//  o_cen_lost     out  1  enable stream stalled
// BEHAVIOUR
//  - Single clock domain: i_clk; reset synchronous, active high; all outputs registered.
//  - Reset: o_hcnt=H_TOTAL-1, o_vcnt=V_TOTAL-1, hblank=vblank=1, hsync=vsync=0,
//    de=0, line_start=frame_start=0, cen_lost=0, watchdog counter=0.
//    Hence the first i_pix_cen after reset moves to (0,0) and fires frame_start.
//  - On i_clk edge with i_pix_cen=1: hcnt<=hcnt+1, or 0 if hcnt==H_TOTAL-1;
//    on that wrap vcnt<=vcnt+1, or 0 if vcnt==V_TOTAL-1. No change when cen=0.
//  - Flags decoded from NEXT counter values, written the same edge: outputs are
//    always consistent with o_hcnt/o_vcnt in the same cycle (zero extra latency).
//  - hsync=1 for HS_START<=hcnt<HS_END; vsync=1 for VS_START<=vcnt<VS_END.
//  - vcnt/vblank/vsync change only on the cen that wraps hcnt to 0.
//  - line_start/frame_start: high exactly one i_clk cycle (the cycle after the
//    advancing edge), never held across the 7 idle cycles between enables.
//  - Watchdog: 5-bit counter cleared on every cen, saturates; o_cen_lost=1 once
//    counter reaches WDOG; cleared on the edge that samples the next i_pix_cen.
//    Counters hold while stalled; no frame/line strobes without cen.
//  - i_pix_cen held high continuously: counters advance every i_clk (legal, used
//    by fast sim); watchdog stays 0.
//  - i_rst coincident with i_pix_cen: reset wins, counters take reset values.
//  - Reset mid-line: raster restarts; first cen after release gives frame_start.
//  - Parameter legality (not checked in RTL): H_ACTIVE<=HS_START<HS_END<=H_TOTAL<=512,
//    same ordering for V; WDOG<=31.
// TESTING
//  1. Reset, then cen every 8th cycle -> first cen: hcnt=0,vcnt=0,frame_start=1
//     and line_start=1 for 1 cycle, de=1.
//  2. Run one line -> hblank rises at hcnt=256, hsync 1 for hcnt 296..327,
//     hcnt 383->0 increments vcnt to 1, line_start pulse, frame_start=0.
//  3. Run full frame (384*272 cens) -> vblank at vcnt=240, vsync for vcnt 248..250,
//     vcnt 271->0 with frame_start; exactly one frame_start per 104448 cens.
//  4. Stop cen for 20 cycles -> cen_lost=1 at 16th idle cycle, counters frozen;
//     next cen -> cen_lost=0, counter advances by exactly 1.
//  5. Assert i_rst mid-frame at (hcnt=100,vcnt=50) with cen same cycle -> reset
//     values (383,271), de=0; next cen -> (0,0), frame_start=1.
//  6. cen tied high -> hcnt advances every i_clk, cen_lost stays 0, strobes 1 cycle.

Source files
------------

// File: rtl/xsleena_video_timing_gen.sv
// Raster timing generator driven by the pixel clock-enable stream.
// Advances H/V counters on each i_pix_cen pulse and decodes blanking, sync,
// data-enable and line/frame strobes from the next counter values, so every
// flag lines up with o_hcnt/o_vcnt in the same cycle. A small watchdog flags
// a stalled enable stream.
module xsleena_video_timing_gen #(
  parameter int unsigned H_TOTAL  = 384,
  parameter int unsigned H_ACTIVE = 256,
  parameter int unsigned HS_START = 296,
  parameter int unsigned HS_END   = 328,
  parameter int unsigned V_TOTAL  = 272,
  parameter int unsigned V_ACTIVE = 240,
  parameter int unsigned VS_START = 248,
  parameter int unsigned VS_END   = 251,
  parameter int unsigned WDOG     = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_cen,
  output logic [8:0] o_hcnt,
  output logic [8:0] o_vcnt,
  output logic       o_hblank,
  output logic       o_vblank,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_de,
  output logic       o_line_start,
  output logic       o_frame_start,
  output logic       o_cen_lost
);

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
  localparam logic [8:0] HS_S   = 9'(HS_START);
  localparam logic [8:0] HS_E   = 9'(HS_END);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);
  localparam logic [8:0] VS_S   = 9'(VS_START);
  localparam logic [8:0] VS_E   = 9'(VS_END);
  localparam logic [4:0] WDOG_L = 5'(WDOG);
  localparam logic [4:0] WDOG_MAX = 5'h1f;

  logic [8:0] hcnt_nx;
  logic [8:0] vcnt_nx;
  logic [4:0] wdog_cnt;
  logic [4:0] wdog_nx;

  // Next raster position: counters only move on an enable pulse; vertical
  // advances only on the enable that wraps the horizontal counter.
  always_comb begin
    hcnt_nx = o_hcnt;
    vcnt_nx = o_vcnt;
    if (i_pix_cen) begin
      if (o_hcnt == H_LAST) begin
        hcnt_nx = '0;
        vcnt_nx = (o_vcnt == V_LAST) ? 9'd0 : o_vcnt + 9'd1;
      end else begin
        hcnt_nx = o_hcnt + 9'd1;
      end
    end
  end

  // Watchdog next value: cleared by any enable, otherwise counts up and
  // saturates so a long stall never wraps back below the threshold.
  always_comb begin
    wdog_nx = wdog_cnt;
    if (i_pix_cen) begin
      wdog_nx = '0;
    end else if (wdog_cnt != WDOG_MAX) begin
      wdog_nx = wdog_cnt + 5'd1;
    end
  end

  // Register counters and decode flags from the next position.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_hcnt        <= H_LAST;
      o_vcnt        <= V_LAST;
      o_hblank      <= 1'b1;
      o_vblank      <= 1'b1;
      o_hsync       <= 1'b0;
      o_vsync       <= 1'b0;
      o_de          <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_cen_lost    <= 1'b0;
      wdog_cnt      <= '0;
    end else begin
      o_hcnt        <= hcnt_nx;
      o_vcnt        <= vcnt_nx;
      o_hblank      <= (hcnt_nx >= H_ACT);
      o_vblank      <= (vcnt_nx >= V_ACT);
      o_hsync       <= (hcnt_nx >= HS_S) && (hcnt_nx < HS_E);
      o_vsync       <= (vcnt_nx >= VS_S) && (vcnt_nx < VS_E);
      o_de          <= (hcnt_nx < H_ACT) && (vcnt_nx < V_ACT);
      // Strobes are qualified by the enable so they never persist across idle cycles.
      o_line_start  <= i_pix_cen && (hcnt_nx == 9'd0);
      o_frame_start <= i_pix_cen && (hcnt_nx == 9'd0) && (vcnt_nx == 9'd0);
      wdog_cnt      <= wdog_nx;
      o_cen_lost    <= (wdog_nx >= WDOG_L);
    end
  end

endmodule

// File: tb/tb_xsleena_video_timing_gen.sv
// Directed bench for xsleena_video_timing_gen. A default-size instance covers
// reset, line timing, watchdog, continuous enable and reset-with-enable; a
// small-raster instance covers a complete frame wrap in few cycles.
module tb_xsleena_video_timing_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_cen;
  logic [8:0] hcnt, vcnt;
  logic       hblank, vblank, hsync, vsync, de, line_start, frame_start, cen_lost;

  logic       rst2;
  logic       pix_cen2;
  logic [8:0] hcnt2, vcnt2;
  logic       hblank2, vblank2, hsync2, vsync2, de2, ls2, fs2, lost2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  xsleena_video_timing_gen u_dut (
    .i_clk(clk), .i_rst(rst), .i_pix_cen(pix_cen),
    .o_hcnt(hcnt), .o_vcnt(vcnt), .o_hblank(hblank), .o_vblank(vblank),
    .o_hsync(hsync), .o_vsync(vsync), .o_de(de),
    .o_line_start(line_start), .o_frame_start(frame_start), .o_cen_lost(cen_lost)
  );

  xsleena_video_timing_gen #(
    .H_TOTAL(12), .H_ACTIVE(8), .HS_START(9), .HS_END(11),
    .V_TOTAL(8), .V_ACTIVE(5), .VS_START(6), .VS_END(7), .WDOG(16)
  ) u_small (
    .i_clk(clk), .i_rst(rst2), .i_pix_cen(pix_cen2),
    .o_hcnt(hcnt2), .o_vcnt(vcnt2), .o_hblank(hblank2), .o_vblank(vblank2),
    .o_hsync(hsync2), .o_vsync(vsync2), .o_de(de2),
    .o_line_start(ls2), .o_frame_start(fs2), .o_cen_lost(lost2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input int h, input int v);
    chk({tag, ".hcnt"}, 32'(hcnt), 32'(h));
    chk({tag, ".vcnt"}, 32'(vcnt), 32'(v));
  endtask

  // One enable pulse followed by seven idle cycles, n times.
  task automatic adv(input int n);
    repeat (n) begin
      pix_cen = 1'b1;
      tick();
      pix_cen = 1'b0;
      repeat (7) tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    int fs_count;
    int idx, eh, ev;
    rst = 1'b1; pix_cen = 1'b0;
    rst2 = 1'b1; pix_cen2 = 1'b0;
    tick(); tick();

    // Reset state
    chk_pos("rst", 383, 271);
    chk("rst.hblank", 32'(hblank), 1);
    chk("rst.vblank", 32'(vblank), 1);
    chk("rst.hsync", 32'(hsync), 0);
    chk("rst.vsync", 32'(vsync), 0);
    chk("rst.de", 32'(de), 0);
    chk("rst.ls", 32'(line_start), 0);
    chk("rst.fs", 32'(frame_start), 0);
    chk("rst.lost", 32'(cen_lost), 0);
    rst = 1'b0;

    // First enable after reset lands on (0,0) with both strobes
    pix_cen = 1'b1; tick();
    chk_pos("first", 0, 0);
    chk("first.fs", 32'(frame_start), 1);
    chk("first.ls", 32'(line_start), 1);
    chk("first.de", 32'(de), 1);
    chk("first.hblank", 32'(hblank), 0);
    chk("first.vblank", 32'(vblank), 0);
    pix_cen = 1'b0; tick();
    chk("first.fs_drop", 32'(frame_start), 0);
    chk("first.ls_drop", 32'(line_start), 0);
    chk_pos("first.hold", 0, 0);
    repeat (6) tick();

    // One line at cen every 8th cycle
    adv(255);
    chk_pos("h255", 255, 0);
    chk("h255.hblank", 32'(hblank), 0);
    chk("h255.de", 32'(de), 1);
    adv(1);
    chk("h256.hcnt", 32'(hcnt), 256);
    chk("h256.hblank", 32'(hblank), 1);
    chk("h256.de", 32'(de), 0);
    adv(39);
    chk("h295.hcnt", 32'(hcnt), 295);
    chk("h295.hsync", 32'(hsync), 0);
    adv(1);
    chk("h296.hsync", 32'(hsync), 1);
    adv(31);
    chk("h327.hcnt", 32'(hcnt), 327);
    chk("h327.hsync", 32'(hsync), 1);
    adv(1);
    chk("h328.hsync", 32'(hsync), 0);
    adv(55);
    chk_pos("h383", 383, 0);
    chk("h383.hblank", 32'(hblank), 1);
    pix_cen = 1'b1; tick();
    chk_pos("wrap", 0, 1);
    chk("wrap.ls", 32'(line_start), 1);
    chk("wrap.fs", 32'(frame_start), 0);
    chk("wrap.de", 32'(de), 1);
    pix_cen = 1'b0; tick();
    chk("wrap.ls_drop", 32'(line_start), 0);
    repeat (6) tick();

    // Watchdog: stall, counters frozen, recover with a single advance
    pix_cen = 1'b1; tick();
    chk_pos("wd.start", 1, 1);
    pix_cen = 1'b0;
    repeat (15) tick();
    chk("wd.idle15", 32'(cen_lost), 0);
    tick();
    chk("wd.idle16", 32'(cen_lost), 1);
    chk_pos("wd.frozen16", 1, 1);
    repeat (24) tick();
    chk("wd.idle40", 32'(cen_lost), 1);
    chk_pos("wd.frozen40", 1, 1);
    chk("wd.no_ls", 32'(line_start), 0);
    pix_cen = 1'b1; tick();
    chk("wd.recover", 32'(cen_lost), 0);
    chk_pos("wd.step1", 2, 1);

    // Enable tied high: advance every clock
    repeat (381) tick();
    chk_pos("cont.h383", 383, 1);
    chk("cont.ls0", 32'(line_start), 0);
    tick();
    chk_pos("cont.wrap", 0, 2);
    chk("cont.ls", 32'(line_start), 1);
    tick();
    chk_pos("cont.next", 1, 2);
    chk("cont.ls_drop", 32'(line_start), 0);
    repeat (18531) tick();
    chk_pos("cont.target", 100, 50);
    chk("cont.lost", 32'(cen_lost), 0);
    chk("cont.de", 32'(de), 1);

    // Reset with enable in the same cycle: reset wins
    rst = 1'b1; tick();
    chk_pos("rstcen", 383, 271);
    chk("rstcen.de", 32'(de), 0);
    chk("rstcen.fs", 32'(frame_start), 0);
    rst = 1'b0; pix_cen = 1'b0; tick();
    chk_pos("rstcen.hold", 383, 271);
    pix_cen = 1'b1; tick();
    chk_pos("rstcen.first", 0, 0);
    chk("rstcen.fs1", 32'(frame_start), 1);
    chk("rstcen.ls1", 32'(line_start), 1);
    pix_cen = 1'b0; tick();
    chk("rstcen.fs_drop", 32'(frame_start), 0);

    // Full frame on the 12x8 raster: blanking/sync rows and one frame_start per 96 cens
    rst2 = 1'b0; pix_cen2 = 1'b1;
    fs_count = 0;
    for (int i = 1; i <= 97; i++) begin
      tick();
      idx = (i - 1) % 96;
      eh = idx % 12;
      ev = idx / 12;
      if (i >= 2 && fs2) fs_count++;
      if (eh == 0) begin
        chk("frm.vcnt", 32'(vcnt2), 32'(ev));
        chk("frm.vblank", 32'(vblank2), (ev >= 5) ? 1 : 0);
        chk("frm.vsync", 32'(vsync2), (ev == 6) ? 1 : 0);
        chk("frm.fs", 32'(fs2), (ev == 0) ? 1 : 0);
        chk("frm.ls", 32'(ls2), 1);
      end
      if (eh == 9) chk("frm.hsync", 32'(hsync2), 1);
      if (eh == 8) chk("frm.hblank", 32'(hblank2), 1);
    end
    chk("frm.fs_count", 32'(fs_count), 1);
    chk("frm.end_h", 32'(hcnt2), 0);
    chk("frm.lost", 32'(lost2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
